// File: rtl/stp16_pkg.sv
// Shared types and helpers for the STP16CPC26 chain driver.
package stp16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LATCH = 2'd3
  } stp16_state_e;

  // Width of a counter that must hold values 0..bits inclusive.
  function automatic int bit_cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/stp16_pwm.sv
// Brightness PWM for the STP16 output-enable pin; brightness only changes on latch completion.
module stp16_pwm #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                latch_done,
  input  logic [PWM_BITS-1:0] bright,
  output logic                noe
);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] pending_q;
  logic [PWM_BITS-1:0] active_q;
  logic                enabled_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      pending_q <= '0;
      active_q  <= '0;
      enabled_q <= 1'b0;
      noe       <= 1'b1;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (load) pending_q <= bright;
      // The frame now on the LED outputs is the one just latched, so its brightness applies.
      if (latch_done) begin
        active_q  <= pending_q;
        enabled_q <= 1'b1;
      end
      noe <= !(enabled_q && (pwm_cnt_q < active_q));
    end
  end

endmodule

// File: rtl/stp16_chain_driver.sv
// Serial driver for parallel STP16CPC26 chains: holding register, shift FSM and PWM dimming.
module stp16_chain_driver
  import stp16_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int BITS         = 32,
  parameter int DIV          = 1,
  parameter int LATCH_CYCLES = 1,
  parameter int PWM_BITS     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [CHANNELS*BITS-1:0] i_data,
  input  logic [PWM_BITS-1:0]      i_bright,
  output logic                     o_frame_done,
  output logic                     stp16_clk,
  output logic                     stp16_le,
  output logic                     stp16_noe,
  output logic [CHANNELS-1:0]      stp16_sdi,
  output stp16_state_e             dbg_state
);

  localparam int CW        = bit_cnt_width(BITS);
  localparam int PHASE_MAX = (DIV > LATCH_CYCLES) ? DIV : LATCH_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BITS - 1);

  stp16_state_e state_q, state_d;
  logic [PW-1:0] phase_q;
  logic [CW-1:0] bit_cnt_q;
  logic [CHANNELS-1:0][BITS-1:0] shift_q, shift_d;
  logic                     held_q;
  logic [CHANNELS*BITS-1:0] hold_data_q;
  logic [PWM_BITS-1:0]      hold_bright_q;
  logic [CHANNELS-1:0]      sdi_d;
  logic load, shift_step, latch_done, accept;

  // Handshake: a frame transfers on any cycle where i_valid && i_ready; i_ready is
  // simply "holding register empty", so i_valid may be held until the transfer happens.
  assign i_ready   = !held_q;
  assign accept    = i_valid && !held_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    shift_step = 1'b0;
    latch_done = 1'b0;
    case (state_q)
      ST_IDLE: if (held_q) begin
        load    = 1'b1;
        state_d = ST_LOW;
      end
      ST_LOW: if (phase_q == DIV_LAST) state_d = ST_HIGH;
      ST_HIGH: if (phase_q == DIV_LAST) begin
        shift_step = 1'b1;
        state_d    = (bit_cnt_q == BIT_LAST) ? ST_LATCH : ST_LOW;
      end
      ST_LATCH: if (phase_q == LATCH_LAST) begin
        latch_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = hold_data_q;
    end else if (shift_step) begin
      for (int c = 0; c < CHANNELS; c++) shift_d[c] = {shift_q[c][BITS-2:0], 1'b0};
    end
  end

  // Pins are registered from next-state values so they line up with the state they belong to.
  always_comb begin
    sdi_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (state_d == ST_LOW || state_d == ST_HIGH) sdi_d[c] = shift_d[c][BITS-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      held_q        <= 1'b0;
      hold_data_q   <= '0;
      hold_bright_q <= '0;
      stp16_clk     <= 1'b0;
      stp16_le      <= 1'b0;
      stp16_sdi     <= '0;
      o_frame_done  <= 1'b0;
    end else begin
      phase_q <= (state_d != state_q || state_q == ST_IDLE) ? '0 : phase_q + 1'b1;
      shift_q <= shift_d;
      if (load)            bit_cnt_q <= '0;
      else if (shift_step) bit_cnt_q <= bit_cnt_q + 1'b1;
      if (accept) begin
        held_q        <= 1'b1;
        hold_data_q   <= i_data;
        hold_bright_q <= i_bright;
      end else if (load) begin
        held_q <= 1'b0;
      end
      stp16_clk    <= (state_d == ST_HIGH);
      stp16_le     <= (state_d == ST_LATCH);
      stp16_sdi    <= sdi_d;
      o_frame_done <= latch_done;
    end
  end

  stp16_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .latch_done (latch_done),
    .bright     (hold_bright_q),
    .noe        (stp16_noe)
  );

endmodule

// File: tb/tb_stp16_chain_driver.sv
// Bench for stp16_chain_driver: DUT A (DIV=1, LATCH=1) and DUT B (DIV=3, LATCH=2), 2x16-bit chains.
module tb_stp16_chain_driver;
  import stp16_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        valid_a, valid_b;
  logic [31:0] data_a, data_b;
  logic [3:0]  bright_a, bright_b;
  logic [1:0]  s_ready, s_done, s_clk, s_le, s_noe;
  logic [1:0]  s_sdi0, s_sdi1;
  stp16_state_e state_a, state_b;

  stp16_chain_driver #(.CHANNELS(2), .BITS(16), .DIV(1), .LATCH_CYCLES(1), .PWM_BITS(4)) dut_a (
    .clk(clk), .reset(reset), .i_valid(valid_a), .i_ready(s_ready[0]), .i_data(data_a),
    .i_bright(bright_a), .o_frame_done(s_done[0]), .stp16_clk(s_clk[0]), .stp16_le(s_le[0]),
    .stp16_noe(s_noe[0]), .stp16_sdi(s_sdi0), .dbg_state(state_a));

  stp16_chain_driver #(.CHANNELS(2), .BITS(16), .DIV(3), .LATCH_CYCLES(2), .PWM_BITS(4)) dut_b (
    .clk(clk), .reset(reset), .i_valid(valid_b), .i_ready(s_ready[1]), .i_data(data_b),
    .i_bright(bright_b), .o_frame_done(s_done[1]), .stp16_clk(s_clk[1]), .stp16_le(s_le[1]),
    .stp16_noe(s_noe[1]), .stp16_sdi(s_sdi1), .dbg_state(state_b));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int latch_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  int cyc = 0;
  int edges[2], hi_len[2], lo_len[2], le_len[2], rise_cyc[2], done_cyc[2], gap[2], done_cnt[2];
  logic [15:0] cap0[2], cap1[2];
  logic prev_clk[2], prev_ready[2], prev_done[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0; done_cyc[k] = 0; gap[k] = 0; rise_cyc[k] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      logic [1:0]  sdi_k;
      logic [31:0] ex;
      logic        have;
      sdi_k = (k == 0) ? s_sdi0 : s_sdi1;
      if (reset) begin
        prev_clk[k] = 1'b0; prev_ready[k] = 1'b1; prev_done[k] = 1'b0;
        edges[k] = 0; hi_len[k] = 0; lo_len[k] = 0; le_len[k] = 0;
        cap0[k] = '0; cap1[k] = '0;
      end else begin
        if (s_clk[k] && !prev_clk[k]) begin
          if (edges[k] > 0) check($sformatf("clk_low_len_dut%0d", k), lo_len[k], div_of(k));
          cap0[k] = {cap0[k][14:0], sdi_k[0]};
          cap1[k] = {cap1[k][14:0], sdi_k[1]};
          edges[k]++;
          hi_len[k] = 0;
        end
        if (!s_clk[k] && prev_clk[k]) begin
          check($sformatf("clk_high_len_dut%0d", k), hi_len[k], div_of(k));
          lo_len[k] = 0;
        end
        if (s_clk[k]) hi_len[k]++; else lo_len[k]++;
        if (s_le[k]) le_len[k]++;
        if (s_ready[k] && !prev_ready[k]) rise_cyc[k] = cyc;
        if (s_done[k]) begin
          check($sformatf("done_width_dut%0d", k), prev_done[k], 0);
          check($sformatf("edge_count_dut%0d", k), edges[k], 16);
          check($sformatf("le_len_dut%0d", k), le_len[k], latch_of(k));
          check($sformatf("frame_len_dut%0d", k), cyc - rise_cyc[k], 2 * div_of(k) * 16 + latch_of(k));
          have = 1'b0;
          ex = '0;
          if (k == 0 && exp_q_a.size() > 0) begin ex = exp_q_a.pop_front(); have = 1'b1; end
          if (k == 1 && exp_q_b.size() > 0) begin ex = exp_q_b.pop_front(); have = 1'b1; end
          check($sformatf("sb_entry_dut%0d", k), have, 1);
          if (have) begin
            check($sformatf("ch0_data_dut%0d", k), cap0[k], ex[15:0]);
            check($sformatf("ch1_data_dut%0d", k), cap1[k], ex[31:16]);
          end
          gap[k] = cyc - done_cyc[k];
          done_cyc[k] = cyc;
          done_cnt[k]++;
          edges[k] = 0;
          le_len[k] = 0;
        end
        prev_clk[k]   = s_clk[k];
        prev_ready[k] = s_ready[k];
        prev_done[k]  = s_done[k];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int k, input logic [15:0] c0, input logic [15:0] c1,
                      input logic [3:0] br, output int waited);
    waited = 0;
    @(negedge clk); #1;
    while (s_ready[k] !== 1'b1 && waited < 400) begin
      @(negedge clk); #1;
      waited++;
    end
    check($sformatf("send_wait_dut%0d", k), waited < 400, 1);
    if (k == 0) begin
      data_a = {c1, c0}; bright_a = br; valid_a = 1'b1; exp_q_a.push_back({c1, c0});
    end else begin
      data_b = {c1, c0}; bright_b = br; valid_b = 1'b1; exp_q_b.push_back({c1, c0});
    end
    @(negedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic wait_done(input int k, input int target);
    int budget;
    budget = 0;
    while (done_cnt[k] < target && budget < 500) begin
      @(negedge clk); #1;
      budget++;
    end
    check($sformatf("done_wait_dut%0d", k), budget < 500, 1);
  endtask

  task automatic wait_edges(input int k, input int n);
    int budget;
    budget = 0;
    while (edges[k] < n && budget < 500) begin
      @(negedge clk); #1;
      budget++;
    end
    check($sformatf("edge_wait_dut%0d", k), budget < 500, 1);
  endtask

  task automatic count_noe_low(input int k, input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk); #1;
      if (s_noe[k] === 1'b0) lows++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   w, lows;
    logic act;
    reset = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0; bright_a = '0; bright_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;

    // Idle after reset: nothing moves for a long stretch.
    act = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      act = act | (|s_clk) | (|s_le) | !(&s_noe) | (|s_sdi0) | (|s_sdi1) | (|s_done) | !(&s_ready);
    end
    check("idle_activity", act, 0);
    check("rst_noe", s_noe, 2'b11);
    check("rst_ready", s_ready, 2'b11);
    check("rst_state", state_a, ST_IDLE);

    // Reference frame at full brightness.
    send(0, 16'hA5C3, 16'h0F01, 4'hF, w);
    wait_done(0, 1);
    repeat (2) @(negedge clk);
    count_noe_low(0, 16, lows);
    check("pwm_bright15", lows, 15);

    // Two frames back to back: second accepted the cycle after the first loads.
    send(0, 16'h1234, 16'h8001, 4'd4, w);
    send(0, 16'hFFFF, 16'h0000, 4'd4, w);
    check("accept_after_load", w, 0);
    check("ready_low_while_held", s_ready[0], 0);
    wait_done(0, 3);
    check("b2b_done_gap", gap[0], 34);
    repeat (2) @(negedge clk);
    count_noe_low(0, 16, lows);
    check("pwm_bright4", lows, 4);

    // Brightness 0: old brightness persists during shifting, then outputs go dark.
    send(0, 16'h0001, 16'h8000, 4'd0, w);
    wait_edges(0, 2);
    count_noe_low(0, 16, lows);
    check("pwm_hold_midframe", lows, 4);
    wait_done(0, 4);
    repeat (2) @(negedge clk);
    count_noe_low(0, 32, lows);
    check("pwm_bright0", lows, 0);

    // Reset mid-shift, then a fresh frame must shift from bit 0.
    send(0, 16'hDEAD, 16'hBEEF, 4'd9, w);
    wait_edges(0, 7);
    reset = 1'b1;
    #1;
    check("midrst_clk", s_clk[0], 0);
    check("midrst_le", s_le[0], 0);
    check("midrst_noe", s_noe[0], 1);
    check("midrst_sdi", s_sdi0, 2'b00);
    check("midrst_ready", s_ready[0], 1);
    check("midrst_state", state_a, ST_IDLE);
    exp_q_a.delete();
    @(negedge clk); #1;
    reset = 1'b0;
    send(0, 16'h5A3C, 16'hC3A5, 4'd8, w);
    wait_edges(0, 4);
    check("noe_dark_until_latch", s_noe[0], 1);
    wait_done(0, 5);
    repeat (2) @(negedge clk);
    count_noe_low(0, 16, lows);
    check("pwm_bright8", lows, 8);

    // Slow divider and wide latch on the second instance.
    send(1, 16'h6B2D, 16'h9E47, 4'd2, w);
    wait_done(1, 1);

    check("frames_done_a", done_cnt[0], 5);
    check("frames_done_b", done_cnt[1], 1);
    check("sb_drained", exp_q_a.size() + exp_q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
